gelato_inst_fetch_pipe: RTL and testbench

Multi-outstanding instruction fetch unit between the fetch scheduler (PC table) and the instruction decode/buffer stage. It accepts warp PCs on a valid/ready handshake and issues tagged requests to the I-cache. It tracks up to DEPTH in-flight fetches in a ring of slots, so responses may return out of order. It delivers instructions to decode strictly in request order, and supports a flush that squashes every in-flight fetch without stalling the cache.

---
 rtl/gelato_ifetch_pkg.sv | 27 ++
 rtl/gelato_ifetch_slot_ring.sv | 136 +++++++++++++
 rtl/gelato_inst_fetch_pipe.sv | 107 ++++++++++
 tb/tb_gelato_inst_fetch_pipe.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_ifetch_pkg.sv
// Shared types and default widths for the gelato instruction fetch pipe.
package gelato_ifetch_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_INST_W  = 32;
  localparam int unsigned DEF_WARP_W  = 5;
  localparam int unsigned DEF_SPLIT_W = 4;
  localparam int unsigned DEF_DEPTH   = 4;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_ISSUED = 2'd1,
    SLOT_DONE   = 2'd2
  } slot_state_t;

  // Default-width view of one slot; modules with other widths declare
  // an equivalent struct from their own parameters.
  typedef struct packed {
    slot_state_t              state;
    logic                     squash;
    logic [DEF_ADDR_W-1:0]    pc;
    logic [DEF_WARP_W-1:0]    warp;
    logic [DEF_SPLIT_W-1:0]   split;
    logic [DEF_INST_W-1:0]    inst;
  } slot_t;

endpackage

// File: rtl/gelato_ifetch_slot_ring.sv
// Ring of in-flight fetch slots. Allocation at tail, completion by tag in
// any order, retirement strictly from head. Squashed slots drain silently.
module gelato_ifetch_slot_ring
  import gelato_ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned WARP_W  = DEF_WARP_W,
  parameter int unsigned SPLIT_W = DEF_SPLIT_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic               i_alloc,
  input  logic [ADDR_W-1:0]  i_alloc_pc,
  input  logic [WARP_W-1:0]  i_alloc_warp,
  input  logic [SPLIT_W-1:0] i_alloc_split,
  input  logic               i_cmpl_valid,
  input  logic [TAG_W-1:0]   i_cmpl_tag,
  input  logic [INST_W-1:0]  i_cmpl_data,
  input  logic               i_retire,
  output logic [TAG_W-1:0]   o_tail,
  output logic               o_full,
  output logic               o_head_valid,
  output logic [ADDR_W-1:0]  o_head_pc,
  output logic [WARP_W-1:0]  o_head_warp,
  output logic [SPLIT_W-1:0] o_head_split,
  output logic [INST_W-1:0]  o_head_inst,
  output logic               o_err_tag
);

  typedef struct packed {
    slot_state_t          state;
    logic                 squash;
    logic [ADDR_W-1:0]    pc;
    logic [WARP_W-1:0]    warp;
    logic [SPLIT_W-1:0]   split;
    logic [INST_W-1:0]    inst;
  } ring_slot_t;

  localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   COUNT_FULL = (TAG_W+1)'(DEPTH);

  ring_slot_t       r_slot [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_err_tag;

  logic w_head_done;
  logic w_free_head;
  logic w_cmpl_hit;
  logic w_cmpl_stray;

  assign w_head_done  = (r_slot[r_head].state == SLOT_DONE);
  // A squashed head leaves without a decode handshake.
  assign w_free_head  = i_en && w_head_done && (r_slot[r_head].squash || i_retire);
  assign w_cmpl_hit   = i_cmpl_valid && (r_slot[i_cmpl_tag].state == SLOT_ISSUED);
  assign w_cmpl_stray = i_cmpl_valid && (r_slot[i_cmpl_tag].state == SLOT_FREE);

  assign o_tail       = r_tail;
  assign o_full       = (r_count == COUNT_FULL);
  assign o_head_valid = w_head_done && !r_slot[r_head].squash;
  assign o_head_pc    = r_slot[r_head].pc;
  assign o_head_warp  = r_slot[r_head].warp;
  assign o_head_split = r_slot[r_head].split;
  assign o_head_inst  = r_slot[r_head].inst;
  assign o_err_tag    = r_err_tag;

  // Slot array: flush marks, completion capture, head free, tail allocate.
  // The four writers touch disjoint slots/fields, so ordering is cosmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_en) begin
      if (i_flush) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (r_slot[i].state != SLOT_FREE) begin
            r_slot[i].squash <= 1'b1;
          end
        end
      end
      if (w_cmpl_hit) begin
        r_slot[i_cmpl_tag].state <= SLOT_DONE;
        r_slot[i_cmpl_tag].inst  <= i_cmpl_data;
      end
      if (w_free_head) begin
        r_slot[r_head].state <= SLOT_FREE;
      end
      if (i_alloc) begin
        r_slot[r_tail].state  <= SLOT_ISSUED;
        r_slot[r_tail].squash <= 1'b0;
        r_slot[r_tail].pc     <= i_alloc_pc;
        r_slot[r_tail].warp   <= i_alloc_warp;
        r_slot[r_tail].split  <= i_alloc_split;
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_alloc) begin
        r_tail <= r_tail + TAG_ONE;
      end
      if (w_free_head) begin
        r_head <= r_head + TAG_ONE;
      end
      if (i_alloc && !w_free_head) begin
        r_count <= r_count + CNT_ONE;
      end else if (!i_alloc && w_free_head) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Sticky flag for responses that name a slot with nothing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_tag <= 1'b0;
    end else if (i_en && w_cmpl_stray) begin
      r_err_tag <= 1'b1;
    end
  end

endmodule

// File: rtl/gelato_inst_fetch_pipe.sv
// Multi-outstanding instruction fetch: accepts warp PCs, issues tagged
// I-cache requests, delivers instructions to decode in request order.
module gelato_inst_fetch_pipe
  import gelato_ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned WARP_W  = DEF_WARP_W,
  parameter int unsigned SPLIT_W = DEF_SPLIT_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rdy,
  input  logic               i_flush,
  input  logic               i_pc_valid,
  output logic               o_pc_ready,
  input  logic [ADDR_W-1:0]  i_pc_addr,
  input  logic [WARP_W-1:0]  i_pc_warp,
  input  logic [SPLIT_W-1:0] i_pc_split,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  output logic [TAG_W-1:0]   o_mem_req_tag,
  input  logic               i_mem_rsp_valid,
  input  logic [TAG_W-1:0]   i_mem_rsp_tag,
  input  logic [INST_W-1:0]  i_mem_rsp_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [ADDR_W-1:0]  o_out_pc,
  output logic [WARP_W-1:0]  o_out_warp,
  output logic [SPLIT_W-1:0] o_out_split,
  output logic [INST_W-1:0]  o_out_inst,
  output logic               o_err_tag
);

  logic               r_req_valid;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [TAG_W-1:0]   r_req_tag;

  logic               w_full;
  logic [TAG_W-1:0]   w_tail;
  logic               w_head_valid;
  logic               w_pc_ready;
  logic               w_alloc;
  logic               w_retire;

  // rst_n is folded in so the scheduler sees no ready while held in reset.
  assign w_pc_ready = rst_n && i_rdy && !i_flush && !w_full &&
                      (!r_req_valid || i_mem_req_ready);
  assign w_alloc    = i_pc_valid && w_pc_ready;
  assign w_retire   = i_rdy && w_head_valid && i_out_ready;

  assign o_pc_ready      = w_pc_ready;
  assign o_mem_req_valid = r_req_valid;
  assign o_mem_req_addr  = r_req_addr;
  assign o_mem_req_tag   = r_req_tag;
  assign o_out_valid     = w_head_valid;

  // Issue register: loaded on allocate, dropped once the cache takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_tag   <= '0;
    end else if (i_rdy) begin
      if (w_alloc) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= i_pc_addr;
        r_req_tag   <= w_tail;
      end else if (i_mem_req_ready) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  gelato_ifetch_slot_ring #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .WARP_W  (WARP_W),
    .SPLIT_W (SPLIT_W),
    .DEPTH   (DEPTH)
  ) u_ring (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_rdy),
    .i_flush       (i_flush),
    .i_alloc       (w_alloc),
    .i_alloc_pc    (i_pc_addr),
    .i_alloc_warp  (i_pc_warp),
    .i_alloc_split (i_pc_split),
    .i_cmpl_valid  (i_mem_rsp_valid),
    .i_cmpl_tag    (i_mem_rsp_tag),
    .i_cmpl_data   (i_mem_rsp_data),
    .i_retire      (w_retire),
    .o_tail        (w_tail),
    .o_full        (w_full),
    .o_head_valid  (w_head_valid),
    .o_head_pc     (o_out_pc),
    .o_head_warp   (o_out_warp),
    .o_head_split  (o_out_split),
    .o_head_inst   (o_out_inst),
    .o_err_tag     (o_err_tag)
  );

endmodule

// File: tb/tb_gelato_inst_fetch_pipe.sv
// Directed bench for gelato_inst_fetch_pipe with hand-computed expectations.
module tb_gelato_inst_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy, flush;
  logic        pc_valid, pc_ready;
  logic [31:0] pc_addr;
  logic [4:0]  pc_warp;
  logic [3:0]  pc_split;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_tag;
  logic        mem_rsp_valid;
  logic [1:0]  mem_rsp_tag;
  logic [31:0] mem_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_warp;
  logic [3:0]  out_split;
  logic [31:0] out_inst;
  logic        err_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gelato_inst_fetch_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rdy           (rdy),
    .i_flush         (flush),
    .i_pc_valid      (pc_valid),
    .o_pc_ready      (pc_ready),
    .i_pc_addr       (pc_addr),
    .i_pc_warp       (pc_warp),
    .i_pc_split      (pc_split),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_req_addr  (mem_req_addr),
    .o_mem_req_tag   (mem_req_tag),
    .i_mem_rsp_valid (mem_rsp_valid),
    .i_mem_rsp_tag   (mem_rsp_tag),
    .i_mem_rsp_data  (mem_rsp_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_pc        (out_pc),
    .o_out_warp      (out_warp),
    .o_out_split     (out_split),
    .o_out_inst      (out_inst),
    .o_err_tag       (err_tag)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    rdy = 1'b1; flush = 1'b0;
    pc_valid = 1'b0; pc_addr = '0; pc_warp = '0; pc_split = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rdy = 1'b1; flush = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'h1234; pc_warp = '0; pc_split = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_ready !== 1'b0) begin
      errors++; $display("FAIL reset_pc_ready got %0b exp 0", pc_ready);
    end
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_tag} !== 35'h0) begin
      errors++; $display("FAIL reset_mem_req got v%0b a%h t%0d exp all 0", mem_req_valid, mem_req_addr, mem_req_tag);
    end
    checks++;
    if ({out_valid, out_pc, out_warp, out_split, out_inst, err_tag} !== 75'h0) begin
      errors++; $display("FAIL reset_out got v%0b pc%h w%0d s%0d i%h e%0b exp all 0", out_valid, out_pc, out_warp, out_split, out_inst, err_tag);
    end
    pc_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_pc_ready got %0b exp 1", pc_ready);
    end
  endtask

  task automatic test_single;
    do_reset();
    pc_valid = 1'b1; pc_addr = 32'h100; pc_warp = 5'd3; pc_split = 4'd5;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL single_pc_ready got %0b exp 1", pc_ready);
    end
    tick();
    pc_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_tag} !== {1'b1, 32'h100, 2'd0}) begin
      errors++; $display("FAIL single_mem_req got v%0b a%h t%0d exp v1 a100 t0", mem_req_valid, mem_req_addr, mem_req_tag);
    end
    tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd0; mem_rsp_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL single_pre_rsp got out_valid %0b mem_req_valid %0b exp 0 0", out_valid, mem_req_valid);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_warp, out_split, out_inst} !== {1'b1, 32'h100, 5'd3, 4'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_out got v%0b pc%h w%0d s%0d i%h exp v1 pc100 w3 s5 ideadbeef", out_valid, out_pc, out_warp, out_split, out_inst);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drained got out_valid %0b exp 0", out_valid);
    end
  endtask

  task automatic test_out_of_order;
    logic [1:0] ord [3];
    logic       exp_v [3];
    ord = '{2'd3, 2'd1, 2'd0};
    exp_v = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; pc_addr = 32'(4 * i); pc_warp = 5'(i); pc_split = '0;
      #1;
      checks++;
      if (pc_ready !== 1'b1) begin
        errors++; $display("FAIL ooo_pc_ready_%0d got %0b exp 1", i, pc_ready);
      end
      tick();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== 2'(i)) begin
        errors++; $display("FAIL ooo_req_tag_%0d got v%0b t%0d exp v1 t%0d", i, mem_req_valid, mem_req_tag, i);
      end
    end
    pc_addr = 32'h10;
    #1;
    checks++;
    if (pc_ready !== 1'b0) begin
      errors++; $display("FAIL ooo_full_pc_ready got %0b exp 0", pc_ready);
    end
    pc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_tag = ord[k]; mem_rsp_data = 32'h1000 + 32'(ord[k]);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== exp_v[k]) begin
        errors++; $display("FAIL ooo_valid_after_rsp%0d got %0b exp %0b", ord[k], out_valid, exp_v[k]);
      end
    end
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h1000) begin
      errors++; $display("FAIL ooo_out0 got pc%h i%h exp pc0 i1000", out_pc, out_inst);
    end
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd2; mem_rsp_data = 32'h1002;
    for (int k = 1; k < 4; k++) begin
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(4 * k), 32'h1000 + 32'(k)}) begin
        errors++; $display("FAIL ooo_out%0d got v%0b pc%h i%h exp v1 pc%h i%h", k, out_valid, out_pc, out_inst, 4 * k, 32'h1000 + k);
      end
    end
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL ooo_not_full_pc_ready got %0b exp 1", pc_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ooo_empty got out_valid %0b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; pc_addr = 32'h40 + 32'(4 * i); pc_warp = '0; pc_split = '0;
      tick();
    end
    pc_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      mem_rsp_valid = 1'b1; mem_rsp_tag = 2'(t); mem_rsp_data = 32'h2000 + 32'(t);
      tick();
    end
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_inst, pc_ready} !== {1'b1, 32'h40, 32'h2000, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d got v%0b pc%h i%h rdy%0b exp v1 pc40 i2000 rdy0", c, out_valid, out_pc, out_inst, pc_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h40 + 32'(4 * k), 32'h2000 + 32'(k)}) begin
        errors++; $display("FAIL bp_drain%0d got v%0b pc%h i%h exp v1 pc%h i%h", k, out_valid, out_pc, out_inst, 32'h40 + 4 * k, 32'h2000 + k);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got out_valid %0b exp 0", out_valid);
    end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_addr = 32'h300 + 32'(4 * i); pc_warp = '0; pc_split = '0;
      tick();
    end
    pc_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if ({pc_ready, mem_req_valid, mem_req_addr, mem_req_tag} !== {1'b0, 1'b1, 32'h308, 2'd2}) begin
      errors++; $display("FAIL flush_cycle got rdy%0b v%0b a%h t%0d exp rdy0 v1 a308 t2", pc_ready, mem_req_valid, mem_req_addr, mem_req_tag);
    end
    tick();
    flush = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'h200; pc_warp = 5'd7; pc_split = 4'd2;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL flush_new_pc_ready got %0b exp 1", pc_ready);
    end
    tick();
    pc_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_tag} !== {1'b1, 32'h200, 2'd3}) begin
      errors++; $display("FAIL flush_new_req got v%0b a%h t%0d exp v1 a200 t3", mem_req_valid, mem_req_addr, mem_req_tag);
    end
    for (int t = 0; t < 3; t++) begin
      mem_rsp_valid = 1'b1; mem_rsp_tag = 2'(t); mem_rsp_data = 32'hBAD0 + 32'(t);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_squashed_%0d got out_valid %0b exp 0", t, out_valid);
      end
    end
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd3; mem_rsp_data = 32'hCAFE0200;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_warp, out_split, out_inst, err_tag} !== {1'b1, 32'h200, 5'd7, 4'd2, 32'hCAFE0200, 1'b0}) begin
      errors++; $display("FAIL flush_out got v%0b pc%h w%0d s%0d i%h e%0b exp v1 pc200 w7 s2 icafe0200 e0", out_valid, out_pc, out_warp, out_split, out_inst, err_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty got out_valid %0b exp 0", out_valid);
    end
  endtask

  task automatic test_stray;
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd2; mem_rsp_data = 32'h5555;
    #1;
    checks++;
    if (err_tag !== 1'b0) begin
      errors++; $display("FAIL stray_before got err_tag %0b exp 0", err_tag);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({err_tag, out_valid, pc_ready} !== 3'b101) begin
      errors++; $display("FAIL stray_after got e%0b v%0b rdy%0b exp e1 v0 rdy1", err_tag, out_valid, pc_ready);
    end
    pc_valid = 1'b1; pc_addr = 32'h500; pc_warp = '0; pc_split = '0;
    tick();
    pc_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if ({mem_req_tag, err_tag} !== {2'd0, 1'b1}) begin
      errors++; $display("FAIL stray_occupancy got tag%0d e%0b exp tag0 e1", mem_req_tag, err_tag);
    end
    do_reset();
    #1;
    checks++;
    if (err_tag !== 1'b0) begin
      errors++; $display("FAIL stray_reset_clear got err_tag %0b exp 0", err_tag);
    end
  endtask

  task automatic test_rdy_stall;
    do_reset();
    pc_valid = 1'b1; pc_addr = 32'h40; pc_warp = 5'd1; pc_split = '0;
    tick();
    rdy = 1'b0;
    pc_addr = 32'h44; pc_warp = 5'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({pc_ready, mem_req_valid, mem_req_addr, mem_req_tag, out_valid} !== {1'b0, 1'b1, 32'h40, 2'd0, 1'b0}) begin
        errors++; $display("FAIL rdy_stall_%0d got rdy%0b v%0b a%h t%0d ov%0b exp rdy0 v1 a40 t0 ov0", c, pc_ready, mem_req_valid, mem_req_addr, mem_req_tag, out_valid);
      end
      tick();
    end
    rdy = 1'b1;
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL rdy_resume_pc_ready got %0b exp 1", pc_ready);
    end
    tick();
    pc_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_tag} !== {1'b1, 32'h44, 2'd1}) begin
      errors++; $display("FAIL rdy_second_req got v%0b a%h t%0d exp v1 a44 t1", mem_req_valid, mem_req_addr, mem_req_tag);
    end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd0; mem_rsp_data = 32'h4040;
    tick();
    mem_rsp_valid = 1'b0;
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_warp, out_inst} !== {1'b1, 32'h40, 5'd1, 32'h4040}) begin
        errors++; $display("FAIL rdy_out_hold_%0d got v%0b pc%h w%0d i%h exp v1 pc40 w1 i4040", c, out_valid, out_pc, out_warp, out_inst);
      end
      tick();
    end
    rdy = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd1; mem_rsp_data = 32'h4044;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_warp, out_inst, err_tag} !== {1'b1, 32'h44, 5'd2, 32'h4044, 1'b0}) begin
      errors++; $display("FAIL rdy_out_second got v%0b pc%h w%0d i%h e%0b exp v1 pc44 w2 i4044 e0", out_valid, out_pc, out_warp, out_inst, err_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rdy_empty got out_valid %0b exp 0", out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_backpressure();
    test_flush();
    test_stray();
    test_rdy_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
